// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-way registered operand selector with valid/ready handshake
//
// One-entry output buffer behind an N-way selector. The buffer can be refilled
// in the same cycle it drains, so a stream runs at one transfer per cycle.
// Selector codes that address no input are dropped. They set a sticky error,
// record the offending code and bump a saturating drop counter.
module mux_n_reg #(
  parameter int unsigned             WIDTH     = 32,
  parameter int unsigned             N         = 4,
  parameter int unsigned             SEL_W     = 2,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter int unsigned             CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]     selector,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [SEL_W-1:0]     err_sel,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     drop_cnt
);

  // Registered state
  logic [WIDTH-1:0] data_q,    data_d;
  logic [SEL_W-1:0] sel_q,     sel_d;
  logic             valid_q,   valid_d;
  logic             err_q,     err_d;
  logic [SEL_W-1:0] err_sel_q, err_sel_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Decoded selector
  logic [WIDTH-1:0] sel_data;
  logic             sel_legal;

  // Handshake terms
  logic accept;
  logic pop;

  // The stage accepts when empty or when the consumer drains it this cycle.
  // This is the only combinational path through the block.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  // Select the addressed input. A code is legal only if it matches an existing
  // input, so with N == 2**SEL_W every code is legal and the error path is dead.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (selector == SEL_W'(k)) begin
        sel_data  = data_in[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  // Next-state for the output buffer and the error/drop bookkeeping
  always_comb begin
    data_d    = data_q;
    sel_d     = sel_q;
    valid_d   = valid_q && !out_ready;
    err_d     = err_q;
    err_sel_d = err_sel_q;
    cnt_d     = cnt_q;

    // A clear takes effect unless an illegal transfer arrives in the same cycle
    if (err_clr) begin
      err_d = 1'b0;
    end

    if (accept) begin
      if (sel_legal) begin
        data_d  = sel_data;
        sel_d   = selector;
        valid_d = 1'b1;
      end else begin
        // Dropped transfer: the buffer keeps its old contents, and out_valid
        // falls only if the old contents are being consumed right now
        valid_d   = valid_q && !pop;
        err_d     = 1'b1;
        err_sel_d = selector;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State update with synchronous reset overriding every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VAL;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_sel_q <= err_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign sel_out   = sel_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign err_sel   = err_sel_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - directed self-checking bench for mux_n_reg
module tb_mux_n_reg;

  localparam int unsigned      WIDTH = 32;
  localparam int unsigned      N     = 3;
  localparam int unsigned      SEL_W = 2;
  localparam int unsigned      CNT_W = 2;
  localparam logic [WIDTH-1:0] RVAL  = 32'hCAFE_F00D;

  localparam logic [31:0] IN0 = 32'hAAAA_0000;
  localparam logic [31:0] IN1 = 32'h1234_5678;
  localparam logic [31:0] IN2 = 32'hDEAD_BEEF;

  logic               clk;
  logic               reset;
  logic [N*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]   selector;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_out;
  logic [SEL_W-1:0]   sel_out;
  logic               out_valid;
  logic               out_ready;
  logic               err;
  logic [SEL_W-1:0]   err_sel;
  logic               err_clr;
  logic [CNT_W-1:0]   drop_cnt;

  int checks;
  int failures;

  mux_n_reg #(
    .WIDTH    (WIDTH),
    .N        (N),
    .SEL_W    (SEL_W),
    .RESET_VAL(RVAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .selector (selector),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .sel_out  (sel_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err),
    .err_sel  (err_sel),
    .err_clr  (err_clr),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; selector = '0;
    step();
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (data_out !== RVAL) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_out, RVAL); end
    checks++; if (sel_out !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_sel !== 2'd0) begin failures++; $display("FAIL reset_err_sel got=%0d exp=0", err_sel); end
    checks++; if (drop_cnt !== 2'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; selector = 2'd1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (data_out !== IN1) begin failures++; $display("FAIL basic_data got=%h exp=%h", data_out, IN1); end
    checks++; if (sel_out !== 2'd1) begin failures++; $display("FAIL basic_sel got=%0d exp=1", sel_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid got=%b exp=0", out_valid); end
    checks++; if (data_out !== IN1) begin failures++; $display("FAIL basic_hold_after_pop got=%h exp=%h", data_out, IN1); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; selector = 2'd2; out_ready = 1'b0;
    step();
    checks++; if (data_out !== IN2) begin failures++; $display("FAIL bp_load got=%h exp=%h", data_out, IN2); end
    selector = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      step();
      checks++; if (data_out !== IN2) begin failures++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, data_out, IN2); end
      checks++; if (out_valid !== 1'b1 || sel_out !== 2'd2) begin failures++; $display("FAIL bp_valid_sel[%0d] got=%b/%0d exp=1/2", i, out_valid, sel_out); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== IN0 || out_valid !== 1'b1 || sel_out !== 2'd0) begin failures++; $display("FAIL bp_release got=%h/%b/%0d exp=%h/1/0", data_out, out_valid, sel_out, IN0); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [1:0]  seq  [4];
    logic [31:0] expd [4];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0;
    expd[0] = IN0; expd[1] = IN1; expd[2] = IN2; expd[3] = IN0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; selector = seq[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || data_out !== expd[i] || sel_out !== seq[i]) begin
        failures++; $display("FAIL stream[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, data_out, sel_out, expd[i], seq[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    // buffer is empty and holds IN0 from the last stream beat
    in_valid = 1'b1; selector = 2'd3; out_ready = 1'b1;
    step();
    checks++; if (err !== 1'b1 || err_sel !== 2'd3 || drop_cnt !== 2'd1) begin failures++; $display("FAIL ill_first got=%b/%0d/%0d exp=1/3/1", err, err_sel, drop_cnt); end
    checks++; if (data_out !== IN0 || sel_out !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL ill_unchanged got=%h/%0d/%b exp=%h/0/0", data_out, sel_out, out_valid, IN0); end
    err_clr = 1'b1;
    step();
    checks++; if (err !== 1'b1 || drop_cnt !== 2'd2) begin failures++; $display("FAIL ill_set_wins got=%b/%0d exp=1/2", err, drop_cnt); end
    in_valid = 1'b0;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0 || drop_cnt !== 2'd2 || err_sel !== 2'd3) begin failures++; $display("FAIL ill_clear got=%b/%0d/%0d exp=0/2/3", err, drop_cnt, err_sel); end
    // illegal push while the legal value is being popped empties the stage
    in_valid = 1'b1; selector = 2'd1; out_ready = 1'b0;
    step();
    selector = 2'd3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || data_out !== IN1 || sel_out !== 2'd1 || drop_cnt !== 2'd3 || err !== 1'b1) begin
      failures++; $display("FAIL ill_push_pop got=%b/%h/%0d/%0d/%b exp=0/%h/1/3/1", out_valid, data_out, sel_out, drop_cnt, err, IN1);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; selector = 2'd2; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_loaded got=%b exp=1", out_valid); end
    reset = 1'b1; selector = 2'd1; out_ready = 1'b1; err_clr = 1'b0;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || data_out !== RVAL || err !== 1'b0 || drop_cnt !== 2'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rmid got=%b/%h/%b/%0d/%b exp=0/%h/0/0/1", out_valid, data_out, err, drop_cnt, in_ready, RVAL);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    // an illegal code without in_valid must be ignored
    in_valid = 1'b0; selector = 2'd3; out_ready = 1'b1;
    step();
    checks++; if (err !== 1'b0 || drop_cnt !== 2'd0) begin failures++; $display("FAIL sat_ignored got=%b/%0d exp=0/0", err, drop_cnt); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (drop_cnt !== exp_cnt) begin failures++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, drop_cnt, exp_cnt); end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || data_out !== RVAL) begin failures++; $display("FAIL sat_data got=%b/%h exp=0/%h", out_valid, data_out, RVAL); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    data_in = {IN2, IN1, IN0};
    selector = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; reset = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-way, WIDTH-bit registered operand selector with a valid/ready handshake, for datapath points that need a pipeline boundary after operand selection (ALU source, PC source, memory address). One registered output stage (one-entry buffer) that can be refilled while it drains, so a stream runs at full throughput. Out-of-range selector codes are detected rather than producing undefined output. The accepted transfer is dropped, a sticky error is raised and a saturating drop counter increments.

## Interface
- WIDTH, 32, data width of each input and of the output
- N, 4, number of data inputs (2..2**SEL_W)
- SEL_W, 2, selector width
- RESET_VAL, 0, reset value of data_out
- CNT_W, 8, width of drop counter
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- selector  in  SEL_W  input index, qualified by in_valid
- in_valid  in  1  selector/data_in valid this cycle
- in_ready  out  1  stage can accept this cycle
- data_out  out  WIDTH  registered selected value
- sel_out  out  SEL_W  selector that produced data_out
- out_valid  out  1  data_out holds an unconsumed value
- out_ready  in  1  consumer takes data_out this cycle
- err  out  1  sticky illegal-selector flag
- err_sel  out  SEL_W  selector value of most recent illegal transfer
- err_clr  in  1  clears err
- drop_cnt  out  CNT_W  saturating count of dropped (illegal) transfers

## Operation
- in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
- accept = in_valid && in_ready; pop = out_valid && out_ready.
- Legal accept (selector < N): data_out <= data_in[selector*WIDTH +: WIDTH], sel_out <= selector, out_valid <= 1.
- Illegal accept (selector >= N): data_out/sel_out unchanged. err <= 1, err_sel <= selector, drop_cnt <= drop_cnt+1 unless it is all ones (saturates, no wrap). out_valid <= 0 if pop, else unchanged.
- No accept: out_valid <= out_valid && !out_ready. data_out holds its value after pop (not cleared).
- Push and pop in the same cycle: with a legal selector, out_valid stays 1 and data_out takes the new value. With an illegal selector, out_valid goes to 0.
- err_clr and a new illegal accept in the same cycle: set wins (err stays 1, err_sel updated). err_clr does not clear drop_cnt or err_sel.
- When N == 2**SEL_W, the illegal path is unreachable. err and drop_cnt stay 0.
- Inputs with in_valid=0 are ignored entirely, including illegal selector values.

## Timing
- Latency: 1 cycle from accept to out_valid/data_out.
- Throughput: 1 transfer/cycle when out_ready held high.
- Values held while out_valid && !out_ready: data_out and sel_out stay stable, in_ready=0.
- Reset values: data_out=RESET_VAL, sel_out=0, out_valid=0, err=0, err_sel=0, drop_cnt=0.
- in_ready reads 1 during reset cycle and immediately after reset.
- Reset asserted mid-stream: pending output is discarded. Reset overrides accept, pop and err_clr in the same cycle.
- No combinational path from data_in/selector to any output. The only combinational path is out_ready/out_valid to in_ready.

## Test plan
- N=3, WIDTH=32. in_valid with selector=1, inputs {0xAAAA0000,0x12345678,0xDEADBEEF}, out_ready=1 → next cycle out_valid=1, data_out=0x12345678, sel_out=1.
- Backpressure: load selector=2, then hold out_ready=0 for 3 cycles while in_valid=1 with selector=0 → in_ready=0, data_out stays 0xDEADBEEF. Raise out_ready → next cycle data_out=0xAAAA0000.
- Streaming: out_ready=1, selector sequence 0,1,2,0 on consecutive cycles → four consecutive out_valid cycles with matching data, no bubbles.
- Illegal selector: N=3, selector=3 accepted → err=1, err_sel=3, drop_cnt=1, data_out unchanged. err_clr together with another selector=3 → err stays 1, drop_cnt=2. err_clr alone → err=0, drop_cnt=2.
- Saturation: CNT_W=2, five illegal accepts → drop_cnt=3.
- Reset mid-operation: out_valid=1 with out_ready=0, assert reset one cycle → out_valid=0, data_out=RESET_VAL, err=0, drop_cnt=0, in_ready=1.
